// File: rtl/game_pkg.sv
// Shared types and defaults for the two-player game controller.
//   turn_state_t : turn sequencer FSM states
//   player_t     : active player id (0 or 1)
//   secs_t       : remaining whole seconds of the current turn
//   CLK_HZ_DEF / TURN_SECONDS_DEF : default clock rate and turn length
package game_pkg;

    localparam int unsigned CLK_HZ_DEF       = 50_000_000;
    localparam int unsigned TURN_SECONDS_DEF = 10;
    localparam int unsigned SECS_W           = 4;

    typedef logic player_t;
    typedef logic [SECS_W-1:0] secs_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_AUTO,
        ST_SWITCH,
        ST_HALT
    } turn_state_t;

endpackage

// File: rtl/turn_sequencer_if.sv
// Bundle between the board/input logic (master) and the turn sequencer (slave).
//   start_in          : one-cycle pulse, begin a new game
//   move_valid_in     : one-cycle pulse, move accepted for player_out
//   game_over_in      : level, win/draw detected
//   player_out        : active player
//   turn_active_out   : high while the turn countdown runs
//   secs_left_out     : remaining whole seconds
//   auto_move_req_out : level, automatic move request, held until a move
//   turn_change_out   : one-cycle pulse when the active player changes
//   timeout_out       : one-cycle pulse when a turn expires
interface turn_sequencer_if;
    import game_pkg::*;

    logic    start_in;
    logic    move_valid_in;
    logic    game_over_in;
    player_t player_out;
    logic    turn_active_out;
    secs_t   secs_left_out;
    logic    auto_move_req_out;
    logic    turn_change_out;
    logic    timeout_out;

    modport master (
        output start_in, move_valid_in, game_over_in,
        input  player_out, turn_active_out, secs_left_out,
               auto_move_req_out, turn_change_out, timeout_out
    );

    modport slave (
        input  start_in, move_valid_in, game_over_in,
        output player_out, turn_active_out, secs_left_out,
               auto_move_req_out, turn_change_out, timeout_out
    );

endinterface

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled and flags the
// wrap cycle as a tick.
//   clk_in   : system clock
//   rst_in   : synchronous active-low reset
//   clr_in   : synchronous clear, wins over en_in
//   en_in    : count enable
//   tick_out : high in the wrap cycle (count == CLK_HZ-1 while enabled)
module sec_tick_gen #(
    parameter int unsigned CLK_HZ = game_pkg::CLK_HZ_DEF
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clr_in,
    input  logic en_in,
    output logic tick_out
);

    localparam int unsigned      CNT_W   = $clog2(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_in) begin
            cnt_d = '0;
        end else if (en_in) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_out = en_in && !clr_in && (cnt_q == CNT_MAX);

endmodule

// File: rtl/turn_sequencer.sv
// Per-turn countdown and player alternation for the two-player game.
//   clk_in : system clock
//   rst_in : synchronous active-low reset
//   seq_if : turn_sequencer_if.slave (start/move/game-over in; player,
//            countdown, auto-move request and event pulses out)
// All outputs are registered from the next-state values.
module turn_sequencer
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
    parameter int unsigned TURN_SECONDS = TURN_SECONDS_DEF
) (
    input logic             clk_in,
    input logic             rst_in,
    turn_sequencer_if.slave seq_if
);

    localparam secs_t SECS_FULL = secs_t'(TURN_SECONDS);

    turn_state_t state_q, state_d;
    player_t     player_q, player_d;
    secs_t       secs_q, secs_d;
    logic        active_q, active_d;
    logic        req_q, req_d;
    logic        tchg_q, tchg_d;
    logic        tout_q, tout_d;

    logic presc_clr;
    logic presc_en;
    logic tick;

    // Prescaler is held at zero outside RUN, so every turn starts on a
    // fresh second regardless of how the previous one ended.
    assign presc_clr = (state_q != ST_RUN);
    assign presc_en  = (state_q == ST_RUN);

    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clr_in   (presc_clr),
        .en_in    (presc_en),
        .tick_out (tick)
    );

    // Player toggle and reload happen on the edge into SWITCH, so the SWITCH
    // cycle already shows the new player together with turn_change_out.
    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        secs_d   = secs_q;
        tout_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (seq_if.start_in) begin
                    state_d  = ST_RUN;
                    player_d = '0;
                    secs_d   = SECS_FULL;
                end
            end
            ST_RUN: begin
                if (seq_if.game_over_in) begin
                    state_d = ST_HALT;
                end else if (seq_if.move_valid_in) begin
                    state_d  = ST_SWITCH;
                    player_d = ~player_q;
                    secs_d   = SECS_FULL;
                end else if (tick) begin
                    if (secs_q <= secs_t'(1)) begin
                        state_d = ST_AUTO;
                        secs_d  = '0;
                        tout_d  = 1'b1;
                    end else begin
                        secs_d = secs_q - secs_t'(1);
                    end
                end
            end
            ST_AUTO: begin
                if (seq_if.game_over_in) begin
                    state_d = ST_HALT;
                end else if (seq_if.move_valid_in) begin
                    state_d  = ST_SWITCH;
                    player_d = ~player_q;
                    secs_d   = SECS_FULL;
                end
            end
            ST_SWITCH: begin
                state_d = seq_if.game_over_in ? ST_HALT : ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active_d = (state_d == ST_RUN);
        req_d    = (state_d == ST_AUTO);
        tchg_d   = (state_d == ST_SWITCH);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            player_q <= '0;
            secs_q   <= SECS_FULL;
            active_q <= 1'b0;
            req_q    <= 1'b0;
            tchg_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            secs_q   <= secs_d;
            active_q <= active_d;
            req_q    <= req_d;
            tchg_q   <= tchg_d;
            tout_q   <= tout_d;
        end
    end

    assign seq_if.player_out        = player_q;
    assign seq_if.turn_active_out   = active_q;
    assign seq_if.secs_left_out     = secs_q;
    assign seq_if.auto_move_req_out = req_q;
    assign seq_if.turn_change_out   = tchg_q;
    assign seq_if.timeout_out       = tout_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer with CLK_HZ=4, TURN_SECONDS=3.
// Stimulus queues the expected output vector for a given cycle number; the
// monitor compares at that cycle and flags any pulse or request edge that
// appears on a cycle with no expectation queued.
module tb_turn_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;

    turn_sequencer_if tif ();

    turn_sequencer #(
        .CLK_HZ       (4),
        .TURN_SECONDS (3)
    ) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .seq_if (tif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected vector layout: {player, active, secs[3:0], req, tchg, tout}
    int unsigned exp_cyc_q[$];
    logic [8:0]  exp_vec_q[$];
    string       exp_name_q[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        mon_en   = 1'b0;
    logic        prev_req = 1'b0;
    logic [8:0]  act_vec;
    logic [8:0]  want_vec;
    int unsigned want_cyc;
    string       want_name;
    logic        ev;

    always @(negedge clk) begin
        if (mon_en) begin
            act_vec = {tif.player_out, tif.turn_active_out, tif.secs_left_out,
                       tif.auto_move_req_out, tif.turn_change_out, tif.timeout_out};
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                want_cyc  = exp_cyc_q.pop_front();
                want_vec  = exp_vec_q.pop_front();
                want_name = exp_name_q.pop_front();
                n_checks++;
                $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                         want_name, want_cyc, cyc);
            end
            ev = (tif.timeout_out === 1'b1) || (tif.turn_change_out === 1'b1) ||
                 (tif.auto_move_req_out !== prev_req);
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                want_cyc  = exp_cyc_q.pop_front();
                want_vec  = exp_vec_q.pop_front();
                want_name = exp_name_q.pop_front();
                n_checks++;
                if (act_vec === want_vec) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s @cyc %0d: got p=%0d act=%0d secs=%0d req=%0d tchg=%0d tout=%0d, want p=%0d act=%0d secs=%0d req=%0d tchg=%0d tout=%0d",
                             want_name, cyc,
                             act_vec[8], act_vec[7], act_vec[6:3], act_vec[2], act_vec[1], act_vec[0],
                             want_vec[8], want_vec[7], want_vec[6:3], want_vec[2], want_vec[1], want_vec[0]);
                end
            end else if (ev) begin
                n_checks++;
                $display("FAIL unexpected_event @cyc %0d: got req=%0d (was %0d) tchg=%0d tout=%0d, want no event",
                         cyc, tif.auto_move_req_out, prev_req, tif.turn_change_out, tif.timeout_out);
            end
            prev_req = tif.auto_move_req_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        for (int i = 0; i < 10000 && cyc < c; i++) tick();
    endtask

    task automatic expect_at(input int unsigned c, input string nm,
                             input logic p, input logic a, input logic [3:0] s,
                             input logic r, input logic tc, input logic to);
        int idx;
        idx = 0;
        while (idx < exp_cyc_q.size() && exp_cyc_q[idx] <= c) idx++;
        exp_cyc_q.insert(idx, c);
        exp_vec_q.insert(idx, {p, a, s, r, tc, to});
        exp_name_q.insert(idx, nm);
    endtask

    int unsigned r1, r2, r3, r4, r5;

    initial begin
        rst_n             = 1'b0;
        tif.start_in      = 1'b0;
        tif.move_valid_in = 1'b0;
        tif.game_over_in  = 1'b0;

        repeat (3) tick();
        expect_at(cyc, "reset_state", 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        tick();
        expect_at(cyc, "idle_after_reset", 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);

        // Full turn to timeout, then a long AUTO hold and an acknowledge.
        tif.start_in = 1'b1;
        tick();
        tif.start_in = 1'b0;
        r1 = cyc;
        expect_at(r1,      "run_entry",    1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        expect_at(r1 + 4,  "secs_2",       1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        expect_at(r1 + 8,  "secs_1",       1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        expect_at(r1 + 12, "timeout",      1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        expect_at(r1 + 13, "auto_hold_a",  1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_at(r1 + 20, "auto_hold_b",  1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_at(r1 + 31, "auto_hold_c",  1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        wait_until(r1 + 32);
        tif.move_valid_in = 1'b1;
        expect_at(r1 + 33, "auto_ack_switch", 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0);
        expect_at(r1 + 34, "p1_run_entry",    1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        tif.move_valid_in = 1'b0;

        // Move lands on the final tick: move wins, no timeout.
        r2 = r1 + 34;
        expect_at(r2 + 8,  "p1_secs_1",     1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        expect_at(r2 + 11, "p1_last_cycle", 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        wait_until(r2 + 11);
        tif.move_valid_in = 1'b1;
        expect_at(r2 + 12, "move_beats_tick", 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0);
        expect_at(r2 + 13, "p0_run_entry",    1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        tif.move_valid_in = 1'b0;

        // Next turn must last a full 12 cycles (no inherited partial second).
        r3 = r2 + 13;
        expect_at(r3 + 4,  "fresh_secs_2",  1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        expect_at(r3 + 8,  "fresh_secs_1",  1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        expect_at(r3 + 11, "fresh_last",    1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        expect_at(r3 + 12, "fresh_timeout", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        expect_at(r3 + 13, "fresh_auto",    1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Reset while the request is high, then a move in IDLE.
        wait_until(r3 + 13);
        rst_n = 1'b0;
        expect_at(r3 + 14, "reset_in_auto", 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        tif.move_valid_in = 1'b1;
        expect_at(r3 + 16, "idle_move_ignored_a", 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        expect_at(r3 + 17, "idle_move_ignored_b", 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        tif.move_valid_in = 1'b0;

        // Game over during player 1's turn at secs=2, then restart.
        wait_until(r3 + 17);
        tif.start_in = 1'b1;
        tick();
        tif.start_in = 1'b0;
        r4 = cyc;
        expect_at(r4, "restart_run", 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        tif.move_valid_in = 1'b1;
        expect_at(r4 + 1, "quick_move_switch", 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0);
        expect_at(r4 + 2, "p1_run",            1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        tif.move_valid_in = 1'b0;
        r5 = r4 + 2;
        expect_at(r5 + 4, "p1_secs_2", 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        wait_until(r5 + 5);
        tif.game_over_in = 1'b1;
        expect_at(r5 + 6, "halt_frozen", 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
        wait_until(r5 + 7);
        tif.game_over_in  = 1'b0;
        tif.move_valid_in = 1'b1;
        tick();
        tif.move_valid_in = 1'b0;
        expect_at(r5 + 9, "halt_move_ignored", 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
        wait_until(r5 + 10);
        tif.start_in = 1'b1;
        expect_at(r5 + 11, "halt_restart", 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        tif.start_in = 1'b0;

        // start_in during RUN must not reload the countdown.
        wait_until(r5 + 12);
        tif.start_in = 1'b1;
        tick();
        tif.start_in = 1'b0;
        expect_at(r5 + 14, "run_start_ignored", 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        expect_at(r5 + 15, "run_secs_2",        1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 200 && exp_cyc_q.size() > 0; i++) tick();
        if (exp_cyc_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_cyc_q.size());
        end
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
